// File: rtl/branch_predictor_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_scheduler_if
//  Purpose  : Bundles the fetch, predictor, execute and statistics signals of
//             the branch predictor scheduler into one interface.
//  Modports : slave  - the scheduler (receives lookups/resolves, drives the
//                      predictor ports and statistics)
//             master - the surrounding pipeline / predictor model
//  Revision : 1.0  initial release
// ============================================================================
interface branch_predictor_scheduler_if #(
    parameter int PCW = 16
);
    // fetch side
    logic           fetchValid;
    logic [PCW-1:0] fetchPC;
    logic           fetchReady;
    logic           predValid;
    logic           predTaken;
    // predictor predict port
    logic [PCW-1:0] predictPC;
    logic           predict;
    logic           gPrediction;
    logic           pPrediction;
    logic           prediction;
    // execute side
    logic           resolveValid;
    logic           resolveTaken;
    logic           flush;
    // predictor update port
    logic [PCW-1:0] updatePC;
    logic           update;
    logic           gReality;
    logic           pReality;
    logic           reality;
    // status / performance monitoring
    logic           mispredict;
    logic [15:0]    branchCount;
    logic [15:0]    mispredCount;

    modport slave (
        input  fetchValid, fetchPC, gPrediction, pPrediction, prediction,
               resolveValid, resolveTaken, flush,
        output fetchReady, predValid, predTaken, predictPC, predict,
               updatePC, update, gReality, pReality, reality,
               mispredict, branchCount, mispredCount
    );

    modport master (
        output fetchValid, fetchPC, gPrediction, pPrediction, prediction,
               resolveValid, resolveTaken, flush,
        input  fetchReady, predValid, predTaken, predictPC, predict,
               updatePC, update, gReality, pReality, reality,
               mispredict, branchCount, mispredCount
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_scheduler
//  Purpose  : Sequences a tournament predictor between fetch and execute.
//             Lookups are issued to the predictor and tracked in an in-order
//             resolution queue; resolves from execute update the predictor,
//             flag mispredictions, flush wrong-path entries and bump
//             saturating branch / mispredict counters.
//  Ports    : clk   - clock, rising edge
//             reset - synchronous, active-high
//             bus   - branch_predictor_scheduler_if.slave (fetch, predictor,
//                     execute and statistics signals)
//  Revision : 1.0  initial release
// ============================================================================
module branch_predictor_scheduler #(
    parameter int DEPTH = 4,
    parameter int PCW   = 16
) (
    input  logic clk,
    input  logic reset,
    branch_predictor_scheduler_if.slave bus
);
    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);
    localparam logic [15:0]     c_sat   = 16'hFFFF;

    // Resolution queue. Only the final prediction is kept per entry: the
    // component predictions are never consulted by the scheduler because
    // the predictor is updated with the actual outcome on all three
    // reality ports.
    logic [PCW-1:0]  r_pc [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] r_pred;
    logic [c_aw-1:0] r_head;
    logic [c_aw-1:0] r_tail;
    logic [c_aw:0]   r_count;

    // Lookup accepted last cycle whose predictor result arrives now
    logic            r_cap_valid;
    logic [c_aw-1:0] r_cap_idx;

    // Registered update-port outputs and statistics
    logic            r_update;
    logic [PCW-1:0]  r_update_pc;
    logic            r_reality;
    logic            r_mispredict;
    logic [15:0]     r_branch_cnt;
    logic [15:0]     r_mispred_cnt;

    logic            w_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_resolve;
    logic            w_mis;
    logic            w_clear;
    logic [c_aw:0]   w_inc;
    logic [c_aw:0]   w_dec;

    // Full queue rejects fetch even if a resolve frees a slot this cycle.
    assign w_ready   = (r_count < c_depth) && !reset;
    assign w_accept  = bus.fetchValid && w_ready;
    // A flushed fetch still pulses predict but is never queued.
    assign w_push    = w_accept && !bus.flush;
    // The head must already hold its prediction; a head still being
    // captured this cycle has pending set until the end of the cycle.
    assign w_resolve = bus.resolveValid && !bus.flush &&
                       (r_count != '0) && !r_pend[r_head];
    assign w_mis     = w_resolve && (bus.resolveTaken != r_pred[r_head]);
    assign w_clear   = bus.flush || w_mis;
    assign w_inc     = {{c_aw{1'b0}}, w_push};
    assign w_dec     = {{c_aw{1'b0}}, w_resolve};

    assign bus.fetchReady   = w_ready;
    assign bus.predict      = w_accept;
    assign bus.predictPC    = w_ready ? bus.fetchPC : '0;
    assign bus.predValid    = r_cap_valid;
    assign bus.predTaken    = r_cap_valid & bus.prediction;
    assign bus.update       = r_update;
    assign bus.updatePC     = r_update_pc;
    assign bus.gReality     = r_reality;
    assign bus.pReality     = r_reality;
    assign bus.reality      = r_reality;
    assign bus.mispredict   = r_mispredict;
    assign bus.branchCount  = r_branch_cnt;
    assign bus.mispredCount = r_mispred_cnt;

    // Queue control: pointers, occupancy, pending/prediction flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_pend      <= '0;
            r_pred      <= '0;
            r_cap_valid <= 1'b0;
            r_cap_idx   <= '0;
        end else begin
            // A mispredict also kills a lookup allocated in the same cycle,
            // so its returning prediction must not be reported.
            r_cap_valid <= w_push && !w_mis;
            r_cap_idx   <= r_tail;
            if (w_clear) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_pend  <= '0;
            end else begin
                if (r_cap_valid) begin
                    r_pend[r_cap_idx] <= 1'b0;
                    r_pred[r_cap_idx] <= bus.prediction;
                end
                if (w_push) begin
                    r_pend[r_tail] <= 1'b1;
                    r_tail         <= r_tail + 1'b1;
                end
                if (w_resolve) begin
                    r_head <= r_head + 1'b1;
                end
                r_count <= r_count + w_inc - w_dec;
            end
        end
    end

    // PC storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail] <= bus.fetchPC;
        end
    end

    // Update port and statistics, valid the cycle after a legal resolve
    always_ff @(posedge clk) begin
        if (reset) begin
            r_update      <= 1'b0;
            r_update_pc   <= '0;
            r_reality     <= 1'b0;
            r_mispredict  <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_update     <= w_resolve;
            r_update_pc  <= w_resolve ? r_pc[r_head] : '0;
            r_reality    <= w_resolve & bus.resolveTaken;
            r_mispredict <= w_mis;
            if (w_resolve && (r_branch_cnt != c_sat)) begin
                r_branch_cnt <= r_branch_cnt + 16'd1;
            end
            if (w_mis && (r_mispred_cnt != c_sat)) begin
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor_scheduler
//  Purpose  : Self-checking bench for branch_predictor_scheduler. A queue
//             based reference model predicts every output each cycle; the
//             bench also plays the predictor, returning chosen or random
//             prediction bits the cycle after predict.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor_scheduler;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    branch_predictor_scheduler_if #(.PCW(16)) bus ();

    branch_predictor_scheduler #(.DEPTH(DEPTH), .PCW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] pc;
        bit          cap;
        bit          pred;
    } ent_t;

    ent_t        q[$];
    bit          m_cap_due;
    bit          m_upd;
    logic [15:0] m_upc;
    bit          m_real;
    bit          m_mis;
    int          m_bc;
    int          m_mc;

    task automatic model_reset();
        q.delete();
        m_cap_due = 0;
        m_upd     = 0;
        m_upc     = '0;
        m_real    = 0;
        m_mis     = 0;
        m_bc      = 0;
        m_mc      = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered and left 1ns after a rising edge with the
    // inputs already driven. pr: 0/1 forces the predictor answer, 2 = random.
    task automatic cycle(input int pr);
        bit exp_ready;
        bit acc;
        bit legal;
        bit mis;
        bus.prediction  = (pr == 2) ? 1'($urandom_range(0, 1)) : 1'(pr);
        bus.gPrediction = 1'($urandom_range(0, 1));
        bus.pPrediction = 1'($urandom_range(0, 1));
        #2;
        exp_ready = (q.size() < DEPTH) && !reset;
        acc       = bus.fetchValid && exp_ready;
        chk("fetchReady",   32'(bus.fetchReady),   32'(exp_ready));
        chk("predict",      32'(bus.predict),      32'(acc));
        chk("predictPC",    32'(bus.predictPC),    exp_ready ? 32'(bus.fetchPC) : 32'd0);
        chk("predValid",    32'(bus.predValid),    32'(m_cap_due));
        chk("predTaken",    32'(bus.predTaken),    32'(m_cap_due & bus.prediction));
        chk("update",       32'(bus.update),       32'(m_upd));
        chk("updatePC",     32'(bus.updatePC),     32'(m_upc));
        chk("reality",      32'(bus.reality),      32'(m_real));
        chk("gReality",     32'(bus.gReality),     32'(m_real));
        chk("pReality",     32'(bus.pReality),     32'(m_real));
        chk("mispredict",   32'(bus.mispredict),   32'(m_mis));
        chk("branchCount",  32'(bus.branchCount),  32'(m_bc));
        chk("mispredCount", 32'(bus.mispredCount), 32'(m_mc));

        if (reset) begin
            model_reset();
        end else begin
            legal  = bus.resolveValid && !bus.flush && (q.size() > 0) && q[0].cap;
            mis    = legal && (bus.resolveTaken != q[0].pred);
            m_upd  = legal;
            m_upc  = legal ? q[0].pc : 16'h0;
            m_real = legal && bus.resolveTaken;
            m_mis  = mis;
            if (legal && m_bc < 65535) m_bc++;
            if (mis && m_mc < 65535) m_mc++;
            if (bus.flush || mis) begin
                q.delete();
                m_cap_due = 0;
            end else begin
                if (m_cap_due) begin
                    q[q.size()-1].cap  = 1;
                    q[q.size()-1].pred = bus.prediction;
                end
                if (legal) void'(q.pop_front());
                if (acc) q.push_back('{pc: bus.fetchPC, cap: 1'b0, pred: 1'b0});
                m_cap_due = acc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit fv, input logic [15:0] pc, input bit rv,
                        input bit rt, input bit fl, input int pr);
        bus.fetchValid   = fv;
        bus.fetchPC      = pc;
        bus.resolveValid = rv;
        bus.resolveTaken = rt;
        bus.flush        = fl;
        cycle(pr);
    endtask

    initial begin
        reset            = 1'b1;
        bus.fetchValid   = 1'b0;
        bus.fetchPC      = '0;
        bus.resolveValid = 1'b0;
        bus.resolveTaken = 1'b0;
        bus.flush        = 1'b0;
        bus.prediction   = 1'b0;
        bus.gPrediction  = 1'b0;
        bus.pPrediction  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // reset state, fetch blocked while reset is held
        step(1, 16'h1234, 0, 0, 0, 2);
        reset = 1'b0;

        // lookup 00AA, predictor answers taken
        step(1, 16'h00AA, 0, 0, 0, 2);
        step(1, 16'h00BB, 0, 0, 0, 1);
        chk("tp_predValid_after_AA", 32'(bus.predValid), 32'd1);
        // BB captured while AA is resolved not-taken: mispredict clears queue
        step(0, 16'h0000, 1, 0, 0, 0);
        chk("tp_upd_mis",   32'(bus.update),       32'd1);
        chk("tp_upc_mis",   32'(bus.updatePC),     32'h00AA);
        chk("tp_misp",      32'(bus.mispredict),   32'd1);
        chk("tp_bc_1",      32'(bus.branchCount),  32'd1);
        chk("tp_mc_1",      32'(bus.mispredCount), 32'd1);
        // queue is empty: a resolve now must be ignored
        step(0, 16'h0000, 1, 0, 0, 2);
        step(0, 16'h0000, 0, 0, 0, 2);
        chk("tp_empty_resolve_ignored", 32'(bus.update), 32'd0);

        // correct resolve: predict not-taken, resolve not-taken
        step(1, 16'h00CC, 0, 0, 0, 2);
        step(0, 16'h0000, 0, 0, 0, 0);
        step(0, 16'h0000, 1, 0, 0, 2);
        chk("tp_upd_ok",  32'(bus.update),       32'd1);
        chk("tp_mis_ok",  32'(bus.mispredict),   32'd0);
        chk("tp_bc_2",    32'(bus.branchCount),  32'd2);
        chk("tp_mc_keep", 32'(bus.mispredCount), 32'd1);

        // fill / drain rounds with pointer wrap
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++)
                step(1, 16'(16'h0100 + r * 16 + i), 0, 0, 0, 0);
            step(0, 16'h0000, 0, 0, 0, 0);
            #1 chk("tp_full_ready", 32'(bus.fetchReady), 32'd0);
            step(1, 16'h0EEE, 1, 0, 0, 0);
            step(1, 16'h0F00, 0, 0, 0, 0);
            for (int i = 0; i < DEPTH + 2; i++)
                step(0, 16'h0000, 1, 0, 0, 0);
        end

        // flush with a pending lookup and a simultaneous resolve
        step(1, 16'h00DD, 0, 0, 0, 2);
        step(0, 16'h0000, 0, 0, 0, 0);
        step(1, 16'h00EE, 1, 0, 1, 1);
        chk("tp_flush_no_update", 32'(bus.update),    32'd0);
        chk("tp_flush_no_pred",   32'(bus.predValid), 32'd0);
        step(0, 16'h0000, 1, 0, 0, 2);
        step(0, 16'h0000, 0, 0, 0, 2);
        chk("tp_flush_empty", 32'(bus.update), 32'd0);

        // randomized traffic, with occasional flush and reset
        for (int n = 0; n < 800; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            step(1'($urandom_range(0, 3) != 0), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 19) == 0), 2);
        end
        reset = 1'b0;
        for (int n = 0; n < DEPTH + 4; n++)
            step(0, 16'h0000, 0, 0, 1, 2);

        // preload counters near saturation, then three mispredicted branches
        force dut.r_branch_cnt  = 16'hFFFE;
        force dut.r_mispred_cnt = 16'hFFFE;
        #1;
        release dut.r_branch_cnt;
        release dut.r_mispred_cnt;
        m_bc = 65534;
        m_mc = 65534;
        step(0, 16'h0000, 0, 0, 0, 2);
        for (int k = 0; k < 3; k++) begin
            step(1, 16'(16'h0A00 + k), 0, 0, 0, 2);
            step(0, 16'h0000, 0, 0, 0, 1);
            step(0, 16'h0000, 1, 0, 0, 2);
        end
        chk("tp_bc_sat", 32'(bus.branchCount),  32'hFFFF);
        chk("tp_mc_sat", 32'(bus.mispredCount), 32'hFFFF);
        step(0, 16'h0000, 0, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
